// File: rtl/reg_file_sb.sv
// General-purpose register file with two combinational read ports, one write
// port, optional write-to-read bypass and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] regWrite,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] regA,
  input  logic [ADDR_WIDTH-1:0] regB,
  output logic [DATA_WIDTH-1:0] resultA,
  output logic [DATA_WIDTH-1:0] resultB,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueDest,
  input  logic                  flush,
  output logic                  busyA,
  output logic                  busyB,
  output logic [ADDR_WIDTH:0]   busyCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [ADDR_WIDTH:0]   r_busy_count;

  logic                  w_wr_ok;
  logic                  w_set_ok;
  logic [DEPTH-1:0]      w_busy_nxt;
  logic [ADDR_WIDTH:0]   w_busy_cnt;

  assign w_wr_ok  = writeEnable && !((ZERO_REG != 0) && (regWrite == '0));
  assign w_set_ok = issueValid  && !((ZERO_REG != 0) && (issueDest == '0));

  // Scoreboard update order: writeback clear, then flush, then issue set,
  // so a new producer always wins over the retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (writeEnable) w_busy_nxt[regWrite] = 1'b0;
    if (flush)       w_busy_nxt = '0;
    if (w_set_ok)    w_busy_nxt[issueDest] = 1'b1;
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy_cnt = w_busy_cnt + {{ADDR_WIDTH{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_ok) r_regs[regWrite] <= writeData;
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_busy_cnt;
    end
  end

  always_comb begin
    resultA = r_regs[regA];
    if ((BYPASS != 0) && w_wr_ok && (regWrite == regA)) resultA = writeData;
    if ((ZERO_REG != 0) && (regA == '0)) resultA = '0;
  end

  always_comb begin
    resultB = r_regs[regB];
    if ((BYPASS != 0) && w_wr_ok && (regWrite == regB)) resultB = writeData;
    if ((ZERO_REG != 0) && (regB == '0)) resultB = '0;
  end

  // A writeback landing this cycle satisfies the hazard only when it is forwarded.
  always_comb begin
    busyA = r_busy[regA] && !((BYPASS != 0) && writeEnable && (regWrite == regA));
    busyB = r_busy[regB] && !((BYPASS != 0) && writeEnable && (regWrite == regB));
    if ((ZERO_REG != 0) && (regA == '0)) busyA = 1'b0;
    if ((ZERO_REG != 0) && (regB == '0)) busyB = 1'b0;
  end

  assign busyCount = r_busy_count;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised CPU general-purpose register file: two combinational read ports, one synchronous write port.
- Adds an optional write-to-read bypass and a per-register scoreboard of busy bits for hazard detection.
- Sits between decode (read, issue) and writeback (write).
- Successor to the fixed 32x32 register file: adds reset, width/depth generality, bypass and scoreboard.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary

Ports:
clock  in  1  single clock, rising edge
resetN  in  1  asynchronous, active-low reset
writeEnable  in  1  writeback valid
regWrite  in  ADDR_WIDTH  writeback destination index
writeData  in  DATA_WIDTH  writeback data
regA  in  ADDR_WIDTH  read port A index
regB  in  ADDR_WIDTH  read port B index
resultA  out  DATA_WIDTH  read port A data (combinational)
resultB  out  DATA_WIDTH  read port B data (combinational)
issueValid  in  1  decode issues an instruction that will write issueDest
issueDest  in  ADDR_WIDTH  destination of the issued instruction
flush  in  1  synchronous clear of all busy bits (pipeline flush)
busyA  out  1  regA has a pending producer not satisfied this cycle
busyB  out  1  regB has a pending producer not satisfied this cycle
busyCount  out  ADDR_WIDTH+1  number of busy registers (registered)

Behaviour:
- Reset (resetN=0, async): all registers = 0, all busy bits = 0, busyCount = 0. Held while low. Deassertion takes effect at the next rising edge only.
- Write: at a rising edge, if writeEnable=1, regfile[regWrite] <= writeData.
  - With ZERO_REG=1, writes to index 0 are discarded.
- Read: result = regfile[idx], combinational, zero latency.
  - ZERO_REG=1 and idx=0: result = 0 regardless of any write.
  - BYPASS=1 and writeEnable=1 and regWrite=idx and the write is not discarded: result = writeData in the same cycle.
  - BYPASS=0: the new value is visible from the cycle after the edge.
- Scoreboard update at each rising edge, applied in this order:
  1. clear: if writeEnable, busy[regWrite] <= 0;
  2. flush: if flush, all busy <= 0;
  3. set: if issueValid, busy[issueDest] <= 1.
  - Set has priority: an issue and a writeback to the same register in the same cycle leave it busy (a new producer).
  - flush together with issueValid leaves only issueDest busy.
  - With ZERO_REG=1, index 0 is never set busy.
- busyA/busyB (combinational):
  - busyX = busy[regX] AND NOT (BYPASS=1 AND writeEnable AND regWrite=regX).
  - Same-cycle issue does not affect busyX; it reflects state before the edge.
  - With ZERO_REG=1, busyX = 0 whenever regX = 0.
  - With BYPASS=0, a register being written this cycle still reports busy.
- busyCount: registered popcount of the busy vector after the update, valid the cycle after each edge. Range 0..2**ADDR_WIDTH, with ZERO_REG=1 max = 2**ADDR_WIDTH-1.
- Reset mid-operation: a pending write at a reset-held edge is lost; all state is cleared immediately on resetN falling.
- No X propagation: all storage is reset, so reads after reset return 0.

Test Plan:
- Reset then read: pulse resetN low mid-cycle, read r5 -> resultA=0, busyA=0, busyCount=0; resultA drops to 0 asynchronously on resetN low, without waiting for an edge.
- Write/read with bypass (BYPASS=1): writeEnable=1, regWrite=7, writeData=0xDEADBEEF, regA=7 in the same cycle -> resultA=0xDEADBEEF that cycle and after the edge. Same stimulus with BYPASS=0 -> old value 0 that cycle, 0xDEADBEEF next cycle.
- Zero register: write 0x12345678 to r0, issue to r0 -> resultB (regB=0)=0, busyB=0, busyCount unchanged.
- Scoreboard lifecycle: issue r3 -> next cycle busyA(regA=3)=1, busyCount=1. Writeback r3 -> busyA=0 in the writeback cycle (BYPASS=1), busyCount=0 after the edge.
- Simultaneous events: r4 busy; in one cycle writeback r4 and issue r4 -> r4 stays busy, busyCount=1. Then flush with issue r9 -> only r9 busy, busyCount=1.
- Fill: issue r1..r31 on consecutive cycles (ZERO_REG=1) -> busyCount=31. Flush -> busyCount=0.
